dwc_pair_capture: RTL and testbench

// Upstream staging for the duplicate-with-compare (DWC) comparator. Collects one result word from each of
// two redundant cores, which may arrive on different cycles, and aligns the pair. Drives the comparator
// (data_set/data_a/data_b) and waits for its done/match reply, then reports one verdict per pair.
// A pair-arrival watchdog and a saturating mismatch counter are included.

---
 rtl/dwc_pair_capture.sv | 151 +++++++++++++++
 tb/tb_dwc_pair_capture.sv | 182 ++++++++++++++++++
 2 files changed

// File: rtl/dwc_pair_capture.sv
// Staging in front of the duplicate-with-compare comparator: pairs one word from each redundant core,
// hands the pair to the comparator, and reports a single verdict per pair (match, mismatch or timeout).
module dwc_pair_capture #(
    parameter int DW       = 32,
    parameter int PAIR_TMO = 64,
    parameter int CNT_W    = 16
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             a_valid,
    input  logic [DW-1:0]    a_data,
    output logic             a_ready,
    input  logic             b_valid,
    input  logic [DW-1:0]    b_data,
    output logic             b_ready,
    output logic [31:0]      cmp_set,
    output logic [31:0]      cmp_a,
    output logic [31:0]      cmp_b,
    input  logic             cmp_done,
    input  logic             cmp_match,
    output logic             res_valid,
    output logic             res_match,
    output logic             res_timeout,
    output logic [CNT_W-1:0] mismatch_cnt,
    input  logic             cnt_clear
);

    typedef enum logic [1:0] {IDLE, WAIT_PAIR, CMP, REPORT} state_t;

    localparam int TW = (PAIR_TMO > 1) ? $clog2(PAIR_TMO) : 1;
    localparam logic [TW-1:0] TMO_LAST = TW'(PAIR_TMO - 1);
    localparam logic [31:0] SET_COMPARE = 32'd3;

    state_t            state_reg, state_next;
    logic              a_got_reg, a_got_next;
    logic              b_got_reg, b_got_next;
    logic [TW-1:0]     tmo_cnt_reg, tmo_cnt_next;
    logic              res_valid_reg, res_valid_next;
    logic              res_match_reg, res_match_next;
    logic              res_timeout_reg, res_timeout_next;
    logic [31:0]       cmp_a_reg, cmp_b_reg;
    logic [CNT_W-1:0]  cnt_reg;
    logic              a_acc, b_acc;

    // While waiting for the partner word, the side already captured is held off.
    assign a_ready = (state_reg == IDLE) || ((state_reg == WAIT_PAIR) && !a_got_reg);
    assign b_ready = (state_reg == IDLE) || ((state_reg == WAIT_PAIR) && !b_got_reg);
    assign a_acc   = a_valid && a_ready;
    assign b_acc   = b_valid && b_ready;

    assign cmp_set      = (state_reg == CMP) ? SET_COMPARE : 32'd0;
    assign cmp_a        = cmp_a_reg;
    assign cmp_b        = cmp_b_reg;
    assign res_valid    = res_valid_reg;
    assign res_match    = res_match_reg;
    assign res_timeout  = res_timeout_reg;
    assign mismatch_cnt = cnt_reg;

    always_comb begin
        state_next       = state_reg;
        a_got_next       = a_got_reg;
        b_got_next       = b_got_reg;
        tmo_cnt_next     = tmo_cnt_reg;
        res_valid_next   = 1'b0;
        res_match_next   = res_match_reg;
        res_timeout_next = res_timeout_reg;
        case (state_reg)
            IDLE: begin
                a_got_next   = a_acc;
                b_got_next   = b_acc;
                tmo_cnt_next = '0;
                if (a_acc && b_acc) begin
                    state_next = CMP;
                end else if (a_acc || b_acc) begin
                    state_next = WAIT_PAIR;
                end
            end
            WAIT_PAIR: begin
                // A late arrival on the final cycle still counts as a pair.
                if (a_acc || b_acc) begin
                    a_got_next = 1'b1;
                    b_got_next = 1'b1;
                    state_next = CMP;
                end else if (tmo_cnt_reg == TMO_LAST) begin
                    state_next       = REPORT;
                    res_valid_next   = 1'b1;
                    res_match_next   = 1'b0;
                    res_timeout_next = 1'b1;
                end else begin
                    tmo_cnt_next = tmo_cnt_reg + 1'b1;
                end
            end
            CMP: begin
                if (cmp_done) begin
                    state_next       = REPORT;
                    res_valid_next   = 1'b1;
                    res_match_next   = cmp_match;
                    res_timeout_next = 1'b0;
                end
            end
            REPORT: begin
                a_got_next = 1'b0;
                b_got_next = 1'b0;
                state_next = IDLE;
            end
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_reg       <= IDLE;
            a_got_reg       <= 1'b0;
            b_got_reg       <= 1'b0;
            tmo_cnt_reg     <= '0;
            res_valid_reg   <= 1'b0;
            res_match_reg   <= 1'b0;
            res_timeout_reg <= 1'b0;
        end else begin
            state_reg       <= state_next;
            a_got_reg       <= a_got_next;
            b_got_reg       <= b_got_next;
            tmo_cnt_reg     <= tmo_cnt_next;
            res_valid_reg   <= res_valid_next;
            res_match_reg   <= res_match_next;
            res_timeout_reg <= res_timeout_next;
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            cmp_a_reg <= '0;
            cmp_b_reg <= '0;
        end else begin
            if (a_acc) cmp_a_reg <= 32'(a_data);
            if (b_acc) cmp_b_reg <= 32'(b_data);
        end
    end

    // Counts on the edge that closes REPORT; a clear on that same edge takes precedence.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            cnt_reg <= '0;
        end else if (cnt_clear) begin
            cnt_reg <= '0;
        end else if ((state_reg == REPORT) && (!res_match_reg || res_timeout_reg) && (cnt_reg != '1)) begin
            cnt_reg <= cnt_reg + 1'b1;
        end
    end

endmodule

// File: tb/tb_dwc_pair_capture.sv
// Randomized pair traffic against a transaction-level model of pairing, timeout and verdict counting.
module tb_dwc_pair_capture;

    localparam int DW       = 16;
    localparam int PAIR_TMO = 8;
    localparam int CNT_W    = 2;
    localparam int CNT_MAX  = (1 << CNT_W) - 1;

    logic             clk = 1'b0;
    logic             reset = 1'b0;
    logic             a_valid = 1'b0, b_valid = 1'b0;
    logic [DW-1:0]    a_data = '0, b_data = '0;
    logic             a_ready, b_ready;
    logic [31:0]      cmp_set, cmp_a, cmp_b;
    logic             cmp_done, cmp_match;
    logic             res_valid, res_match, res_timeout;
    logic [CNT_W-1:0] mismatch_cnt;
    logic             cnt_clear = 1'b0;

    int tests_run = 0;
    int tests_failed = 0;
    int model_cnt = 0;
    int cmp_lat = 1;
    int cmp_seen;

    dwc_pair_capture #(.DW(DW), .PAIR_TMO(PAIR_TMO), .CNT_W(CNT_W)) dut (
        .clk(clk), .reset(reset),
        .a_valid(a_valid), .a_data(a_data), .a_ready(a_ready),
        .b_valid(b_valid), .b_data(b_data), .b_ready(b_ready),
        .cmp_set(cmp_set), .cmp_a(cmp_a), .cmp_b(cmp_b),
        .cmp_done(cmp_done), .cmp_match(cmp_match),
        .res_valid(res_valid), .res_match(res_match), .res_timeout(res_timeout),
        .mismatch_cnt(mismatch_cnt), .cnt_clear(cnt_clear)
    );

    always #5 clk = ~clk;

    // Comparator stand-in: raises done after cmp_lat edges of seeing a compare command.
    always @(posedge clk or negedge reset) begin
        if (!reset) begin
            cmp_done  <= 1'b0;
            cmp_match <= 1'b0;
            cmp_seen  <= 0;
        end else if (cmp_set == 32'd3) begin
            cmp_seen  <= cmp_seen + 1;
            cmp_done  <= (cmp_seen + 1 >= cmp_lat);
            cmp_match <= (cmp_a == cmp_b);
        end else begin
            cmp_seen <= 0;
            cmp_done <= 1'b0;
        end
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        tests_run++;
        if (got !== exp) begin
            tests_failed++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    // gap: edges between first and second acceptance (negative = B first); |gap| > PAIR_TMO = second never sent.
    task automatic run_pair(input logic [DW-1:0] a, input logic [DW-1:0] b, input int gap,
                            input int lat, input bit clr);
        int  e, acc1, acc2, mag, exp_e;
        bit  b_first, tmo, got1, got2, done, exp_match, t1, t2;
        logic v1, v2;
        mag       = (gap < 0) ? -gap : gap;
        b_first   = (gap < 0);
        tmo       = (mag > PAIR_TMO);
        exp_match = !tmo && (a == b);
        cmp_lat   = lat;
        e = 0; acc1 = -1; acc2 = -1; got1 = 0; got2 = 0; done = 0;
        while (!done && e < 80) begin
            v1 = !got1;
            v2 = !got2 && !tmo && (e >= mag);
            a_valid = b_first ? v2 : v1;
            b_valid = b_first ? v1 : v2;
            a_data  = a;
            b_data  = b;
            #1;
            if (got1 && !got2 && e == acc1)
                check("hold_ready", {31'd0, b_first ? b_ready : a_ready}, 32'd0);
            t1 = v1 && (b_first ? b_ready : a_ready);
            t2 = v2 && (b_first ? a_ready : b_ready);
            @(posedge clk); #1;
            e++;
            if (t1) begin got1 = 1; acc1 = e; end
            if (t2) begin got2 = 1; acc2 = e; end
            if (got2 && (e == acc2 || e == acc2 + 1))
                check("cmp_set_busy", cmp_set, 32'd3);
            if (got2 && e == acc2) begin
                check("cmp_a", cmp_a, 32'(a));
                check("cmp_b", cmp_b, 32'(b));
            end
            if (res_valid) done = 1;
        end
        a_valid = 1'b0;
        b_valid = 1'b0;
        if (!done) begin
            check("res_seen", 32'd0, 32'd1);
            return;
        end
        exp_e = tmo ? acc1 + PAIR_TMO : acc2 + 1 + lat;
        check("res_latency", e, exp_e);
        check("res_match", {31'd0, res_match}, {31'd0, exp_match});
        check("res_timeout", {31'd0, res_timeout}, {31'd0, tmo});
        check("cmp_set_report", cmp_set, 32'd0);
        if (!exp_match && model_cnt < CNT_MAX) model_cnt++;
        if (clr) model_cnt = 0;
        cnt_clear = clr;
        @(posedge clk); #1;
        cnt_clear = 1'b0;
        check("res_pulse", {31'd0, res_valid}, 32'd0);
        check("res_hold", {31'd0, res_match}, {31'd0, exp_match});
        check("mismatch_cnt", 32'(mismatch_cnt), model_cnt);
        $display("[TB] pair a=%h b=%h gap=%0d lat=%0d -> match=%0d timeout=%0d cnt=%0d",
                 a, b, gap, lat, res_match, res_timeout, mismatch_cnt);
    endtask

    task automatic check_reset_values(input string tag);
        check({tag, "_a_ready"}, {31'd0, a_ready}, 32'd1);
        check({tag, "_b_ready"}, {31'd0, b_ready}, 32'd1);
        check({tag, "_cmp_set"}, cmp_set, 32'd0);
        check({tag, "_cmp_a"}, cmp_a, 32'd0);
        check({tag, "_cmp_b"}, cmp_b, 32'd0);
        check({tag, "_res"}, {29'd0, res_valid, res_match, res_timeout}, 32'd0);
        check({tag, "_cnt"}, 32'(mismatch_cnt), 32'd0);
    endtask

    initial begin
        int quiet;
        logic [DW-1:0] ra, rb;
        #2;
        check_reset_values("reset");
        @(posedge clk); #1;
        reset = 1'b1;
        @(posedge clk); #1;

        run_pair(16'h1234, 16'h1234, 0, 1, 0);          // same-cycle equal pair
        run_pair(16'hDEAD, 16'hBEEF, 5, 1, 0);          // B five edges late, mismatch
        run_pair(16'h00AA, 16'h0000, PAIR_TMO + 1, 1, 0); // A alone -> timeout
        run_pair(16'h5555, 16'h5555, 0, 2, 0);          // next pair from IDLE
        run_pair(16'h7777, 16'h7777, PAIR_TMO, 1, 0);   // B on the timeout cycle
        run_pair(16'h0000, 16'h0BBB, -(PAIR_TMO + 1), 1, 0); // B alone -> timeout
        run_pair(16'hC0DE, 16'hC0DE, -3, 3, 0);         // B first, equal

        for (int i = 0; i < 24; i++) begin
            ra = DW'($urandom);
            rb = ($urandom_range(0, 1) == 0) ? ra : DW'($urandom);
            run_pair(ra, rb, int'($urandom_range(0, 18)) - 9, int'($urandom_range(1, 3)), 0);
        end

        for (int i = 0; i < 4; i++) run_pair(16'h0001, 16'h0002 + 16'(i), 0, 1, 0);
        check("cnt_saturated", 32'(mismatch_cnt), CNT_MAX);
        run_pair(16'h00F0, 16'h000F, 2, 1, 1);          // clear beats increment

        // Reset while the pair sits in CMP: abort with no verdict.
        a_valid = 1'b1; b_valid = 1'b1; a_data = 16'h4242; b_data = 16'h4242;
        @(posedge clk); #1;
        a_valid = 1'b0; b_valid = 1'b0;
        check("pre_reset_cmp", cmp_set, 32'd3);
        reset = 1'b0;
        model_cnt = 0;
        #1;
        check_reset_values("midrst");
        @(posedge clk); #1;
        reset = 1'b1;
        quiet = 0;
        for (int i = 0; i < 5; i++) begin
            @(posedge clk); #1;
            if (res_valid) quiet++;
        end
        check("no_res_after_abort", quiet, 32'd0);
        run_pair(16'h3C3C, 16'h3C3C, 1, 1, 0);
        run_pair(16'h3C3C, 16'h3C3D, 0, 1, 0);

        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
